// File: rtl/cpu_hazard_pkg.sv
// Shared types and helpers for the decode-stage hazard controller.
package cpu_hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_EX = 2'd1,
    FWD_WR = 2'd2
  } fwd_sel_e;

  typedef enum logic {
    HZ_IDLE  = 1'b0,
    HZ_STALL = 1'b1
  } hz_state_e;

  localparam int SAT_W = 32;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                               input logic [SAT_W-1:0] max_val);
    return (value >= max_val) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/cpu_fwd_match.sv
// Per-operand comparator against the EX and WR destinations, with EX-first priority.
module cpu_fwd_match
  import cpu_hazard_pkg::*;
#(
  parameter int REG_AW      = 3,
  parameter int ZERO_REG_EN = 1
) (
  input  logic              dc_valid,
  input  logic              src_used,
  input  logic [REG_AW-1:0] src_idx,
  input  logic              ex_wr_en,
  input  logic [REG_AW-1:0] ex_wr_idx,
  input  logic              wr_wr_en,
  input  logic [REG_AW-1:0] wr_wr_idx,
  output fwd_sel_e          fwd_sel,
  output logic              ex_match
);

  logic src_live;
  logic wr_match;

  // Register 0 is hardwired, so it never needs forwarding or interlocking.
  assign src_live = dc_valid & src_used & ((ZERO_REG_EN == 0) || (src_idx != '0));
  assign ex_match = src_live & ex_wr_en & (src_idx == ex_wr_idx);
  assign wr_match = src_live & wr_wr_en & (src_idx == wr_wr_idx);

  always_comb begin
    fwd_sel = FWD_RF;
    if (ex_match) begin
      fwd_sel = FWD_EX;
    end else if (wr_match) begin
      fwd_sel = FWD_WR;
    end
  end

endmodule

// File: rtl/cpu_hazard_ctrl.sv
// Decode-stage hazard controller: operand forwarding, load-use stall FSM,
// jump flush and saturating stall/flush counters.
module cpu_hazard_ctrl
  import cpu_hazard_pkg::*;
#(
  parameter int NUM_SRC     = 2,
  parameter int REG_AW      = 3,
  parameter int LOAD_STALL  = 1,
  parameter int ZERO_REG_EN = 1,
  parameter int CNT_W       = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_dc_valid,
  input  logic [NUM_SRC*REG_AW-1:0] i_dc_src_idx,
  input  logic [NUM_SRC-1:0]        i_dc_src_used,
  input  logic                      i_ex_wr_en,
  input  logic [REG_AW-1:0]         i_ex_wr_idx,
  input  logic                      i_ex_is_load,
  input  logic                      i_wr_wr_en,
  input  logic [REG_AW-1:0]         i_wr_wr_idx,
  input  logic                      i_ex_jump_taken,
  output logic [2*NUM_SRC-1:0]      o_fwd_sel,
  output logic                      o_pc_ld,
  output logic                      o_ir_dc_ld,
  output logic                      o_ir_dc_sel,
  output logic                      o_pc_ex_ld,
  output logic                      o_ir_ex_ld,
  output logic                      o_ir_ex_sel,
  output logic                      o_stalled,
  output logic [CNT_W-1:0]          o_stall_cnt,
  output logic [CNT_W-1:0]          o_flush_cnt
);

  localparam logic [3:0]       STALL_INIT = 4'(LOAD_STALL - 1);
  localparam logic [SAT_W-1:0] CNT_MAX    = SAT_W'((64'd1 << CNT_W) - 64'd1);

  fwd_sel_e           fwd [NUM_SRC];
  logic [NUM_SRC-1:0] ex_hit;
  logic               hazard;

  hz_state_e  state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       stall_inc, flush_inc;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    cpu_fwd_match #(
      .REG_AW      (REG_AW),
      .ZERO_REG_EN (ZERO_REG_EN)
    ) u_match (
      .dc_valid  (i_dc_valid),
      .src_used  (i_dc_src_used[k]),
      .src_idx   (i_dc_src_idx[k*REG_AW +: REG_AW]),
      .ex_wr_en  (i_ex_wr_en),
      .ex_wr_idx (i_ex_wr_idx),
      .wr_wr_en  (i_wr_wr_en),
      .wr_wr_idx (i_wr_wr_idx),
      .fwd_sel   (fwd[k]),
      .ex_match  (ex_hit[k])
    );
    assign o_fwd_sel[2*k +: 2] = i_reset_n ? 2'(fwd[k]) : 2'b00;
  end

  assign hazard    = i_ex_is_load & (|ex_hit);
  assign o_stalled = (state == HZ_STALL);

  // Jump beats everything; a stall holds PC/decode and bubbles EX.
  always_comb begin
    o_pc_ld     = 1'b1;
    o_ir_dc_ld  = 1'b1;
    o_ir_dc_sel = 1'b0;
    o_pc_ex_ld  = 1'b1;
    o_ir_ex_ld  = 1'b1;
    o_ir_ex_sel = 1'b0;
    state_nxt   = state;
    cnt_nxt     = cnt;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (i_ex_jump_taken) begin
      o_ir_dc_sel = 1'b1;
      o_ir_ex_sel = 1'b1;
      flush_inc   = 1'b1;
      state_nxt   = HZ_IDLE;
      cnt_nxt     = 4'd0;
    end else if (state == HZ_STALL) begin
      o_pc_ld     = 1'b0;
      o_ir_dc_ld  = 1'b0;
      o_ir_ex_sel = 1'b1;
      stall_inc   = 1'b1;
      cnt_nxt     = cnt - 4'd1;
      if (cnt <= 4'd1) begin
        state_nxt = HZ_IDLE;
      end
    end else if (hazard) begin
      o_pc_ld     = 1'b0;
      o_ir_dc_ld  = 1'b0;
      o_ir_ex_sel = 1'b1;
      stall_inc   = 1'b1;
      cnt_nxt     = STALL_INIT;
      state_nxt   = (LOAD_STALL > 1) ? HZ_STALL : HZ_IDLE;
    end
    if (!i_reset_n) begin
      o_pc_ld     = 1'b0;
      o_ir_dc_ld  = 1'b0;
      o_ir_dc_sel = 1'b1;
      o_pc_ex_ld  = 1'b0;
      o_ir_ex_ld  = 1'b0;
      o_ir_ex_sel = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= HZ_IDLE;
      cnt         <= 4'd0;
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (stall_inc) begin
        o_stall_cnt <= CNT_W'(sat_inc(SAT_W'(o_stall_cnt), CNT_MAX));
      end
      if (flush_inc) begin
        o_flush_cnt <= CNT_W'(sat_inc(SAT_W'(o_flush_cnt), CNT_MAX));
      end
    end
  end

endmodule
